// File: rtl/median_filter_stream_pkg.sv
// ============================================================================
//  Module      : median_pkg
//  Description : Shared types and helpers for the streaming median filter:
//                FSM state encoding, window geometry helpers and the
//                border-mode encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package median_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic BORDER_ZERO      = 1'b0;
    localparam logic BORDER_REPLICATE = 1'b1;

    // Half window width H.
    function automatic int half_width(input int window);
        return (window - 1) / 2;
    endfunction

    // Number of samples in the window, N.
    function automatic int num_samples(input int window);
        return window * window;
    endfunction

    // 0-based rank of the median among the N samples, M.
    function automatic int median_index(input int window);
        return (window * window - 1) / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/median_filter_stream_rank_select.sv
// ============================================================================
//  Module      : median_rank_select
//  Description : Picks the median of N samples by rank counting and
//                registers it (1-cycle latency).
//  Ports       : clk, reset (async, active-high)
//                in_valid  - samples carry a window this cycle
//                samples   - N packed samples, sample i at [i*PW +: PW]
//                out_valid - registered in_valid
//                median    - registered median (holds when not valid)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_rank_select
    import median_pkg::*;
#(
    parameter int N           = 9,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [N*PIXEL_WIDTH-1:0]   samples,
    output logic                       out_valid,
    output logic [PIXEL_WIDTH-1:0]     median
);

    localparam int M  = (N - 1) / 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] M_CNT = CW'(M);

    logic [PIXEL_WIDTH-1:0] sel;

    // Sample i is the median when fewer than or equal to M samples are
    // strictly below it and more than M are at or below it. The first such
    // index wins, so equal values resolve to the lowest index.
    always_comb begin
        logic                   found;
        logic [CW-1:0]          n_lt;
        logic [CW-1:0]          n_le;
        logic [PIXEL_WIDTH-1:0] si;
        logic [PIXEL_WIDTH-1:0] sj;
        sel   = '0;
        found = 1'b0;
        n_lt  = '0;
        n_le  = '0;
        si    = '0;
        sj    = '0;
        for (int i = 0; i < N; i++) begin
            si   = samples[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            n_lt = '0;
            n_le = '0;
            for (int j = 0; j < N; j++) begin
                sj = samples[j*PIXEL_WIDTH +: PIXEL_WIDTH];
                if (sj < si)  n_lt = n_lt + 1'b1;
                if (sj <= si) n_le = n_le + 1'b1;
            end
            if (!found && (n_lt <= M_CNT) && (n_le > M_CNT)) begin
                sel   = si;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            median    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) median <= sel;
        end
    end

endmodule

`default_nettype wire

// File: rtl/median_filter_stream.sv
// ============================================================================
//  Module      : median_filter_stream
//  Description : Streaming WINDOW x WINDOW median filter over a ROWS x COLS
//                raster frame with zero-pad or edge-replicate borders.
//  Ports       : clk, reset (async, active-high)
//                start       - begins a frame when idle
//                border_mode - 0 zero pad, 1 replicate; captured on start
//                in_valid / in_ready / in_pixel - input stream handshake
//                out_valid / out_pixel - filtered stream, no backpressure
//                busy        - frame in progress
//                done        - pulse with the last output of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_filter_stream
    import median_pkg::*;
#(
    parameter int ROWS        = 428,
    parameter int COLS        = 320,
    parameter int WINDOW      = 3,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   border_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic                   out_valid,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic                   busy,
    output logic                   done
);

    localparam int H         = half_width(WINDOW);
    localparam int N         = num_samples(WINDOW);
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int WIN_IDX_W = $clog2(WINDOW);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] FILL_ROW = ROW_W'(H);
    localparam logic [COL_W-1:0] FILL_COL = COL_W'(H);

    if (WINDOW != 3 && WINDOW != 5 && WINDOW != 7) begin : g_bad_window
        $error("median_filter_stream: WINDOW must be 3, 5 or 7");
    end
    if (ROWS <= H || COLS <= H) begin : g_bad_frame
        $error("median_filter_stream: frame smaller than half window");
    end

    state_t state, state_next;

    logic                   mode;
    logic [ROW_W-1:0]       pos_row;     // stream position, virtual in FLUSH
    logic [COL_W-1:0]       pos_col;
    logic [ROW_W-1:0]       out_row;     // next output to schedule
    logic [COL_W-1:0]       out_col;
    logic                   all_sched;
    logic                   win_valid;
    logic [ROW_W-1:0]       win_row;     // output coordinate held in win
    logic [COL_W-1:0]       win_col;

    logic transfer, step, sched, in_last, fill_end, out_last, flushing;

    assign transfer = in_valid && in_ready;
    assign flushing = (state == ST_FLUSH) && !all_sched;
    assign in_last  = (pos_row == LAST_ROW) && (pos_col == LAST_COL);
    assign fill_end = (pos_row == FILL_ROW) && (pos_col == FILL_COL);
    assign out_last = (out_row == LAST_ROW) && (out_col == LAST_COL);
    assign step     = transfer || flushing;
    // Output k is scheduled by stream position k + H*COLS + H.
    assign sched    = (transfer && ((state == ST_RUN) || fill_end)) || flushing;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_FILL;
            ST_FILL: begin
                if (transfer && in_last)       state_next = ST_FLUSH;
                else if (transfer && fill_end) state_next = ST_RUN;
            end
            ST_RUN:   if (transfer && in_last) state_next = ST_FLUSH;
            // One extra FLUSH cycle after the last schedule lets the final
            // pixel leave the pipeline together with DONE.
            ST_FLUSH: if (all_sched) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_FILL) || (state == ST_RUN);
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode      <= BORDER_ZERO;
            pos_row   <= '0;
            pos_col   <= '0;
            out_row   <= '0;
            out_col   <= '0;
            all_sched <= 1'b0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                mode      <= border_mode;
                pos_row   <= '0;
                pos_col   <= '0;
                out_row   <= '0;
                out_col   <= '0;
                all_sched <= 1'b0;
            end
            if (step) begin
                if (pos_col == LAST_COL) begin
                    pos_col <= '0;
                    pos_row <= (pos_row == LAST_ROW) ? '0 : pos_row + 1'b1;
                end else begin
                    pos_col <= pos_col + 1'b1;
                end
            end
            win_valid <= sched;
            if (sched) begin
                win_row <= out_row;
                win_col <= out_col;
                if (out_col == LAST_COL) begin
                    out_col <= '0;
                    out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
                if (out_last) all_sched <= 1'b1;
            end
        end
    end

    // ---------------- line buffers and window ----------------
    logic [PIXEL_WIDTH-1:0] line_buf [WINDOW-1][COLS];
    logic [PIXEL_WIDTH-1:0] win      [WINDOW][WINDOW];
    logic [PIXEL_WIDTH-1:0] column   [WINDOW];
    logic [PIXEL_WIDTH-1:0] new_pix;

    // Virtual pixels pushed during FLUSH are never selected by the border
    // logic, so their value is irrelevant; zero keeps them deterministic.
    assign new_pix = (state == ST_FLUSH) ? '0 : in_pixel;

    // column[i] is the pixel (WINDOW-1-i) rows above the current stream
    // position; row 0 of the window is the oldest line.
    always_comb begin
        for (int i = 0; i < WINDOW - 1; i++) begin
            column[i] = line_buf[WINDOW-2-i][pos_col];
        end
        column[WINDOW-1] = new_pix;
    end

    always_ff @(posedge clk) begin
        if (step) begin
            line_buf[0][pos_col] <= new_pix;
            for (int t = 1; t < WINDOW - 1; t++) begin
                line_buf[t][pos_col] <= line_buf[t-1][pos_col];
            end
            for (int i = 0; i < WINDOW; i++) begin
                for (int j = 0; j < WINDOW - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
                win[i][WINDOW-1] <= column[i];
            end
        end
    end

    // ---------------- border handling ----------------
    // win[i][j] holds the raw stream sample for offset (i-H, j-H) around
    // (win_row, win_col). When that coordinate leaves the frame the raw
    // value belongs to a neighbouring row or another frame, so it is
    // replaced by zero or by the tap at the clamped coordinate, which is
    // always inside the window.
    logic [N*PIXEL_WIDTH-1:0] samples;

    always_comb begin
        int  rr, cc, ri, cj;
        logic in_frame;
        samples  = '0;
        rr       = 0;
        cc       = 0;
        ri       = 0;
        cj       = 0;
        in_frame = 1'b0;
        for (int i = 0; i < WINDOW; i++) begin
            for (int j = 0; j < WINDOW; j++) begin
                rr = int'(win_row) + i - H;
                cc = int'(win_col) + j - H;
                ri = i;
                cj = j;
                if (rr < 0)        ri = i - rr;
                if (rr > ROWS - 1) ri = i - (rr - (ROWS - 1));
                if (cc < 0)        cj = j - cc;
                if (cc > COLS - 1) cj = j - (cc - (COLS - 1));
                in_frame = (ri == i) && (cj == j);
                if (mode == BORDER_REPLICATE || in_frame) begin
                    samples[(i*WINDOW+j)*PIXEL_WIDTH +: PIXEL_WIDTH] =
                        win[WIN_IDX_W'(ri)][WIN_IDX_W'(cj)];
                end
            end
        end
    end

    median_rank_select #(
        .N           (N),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_rank_select (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (win_valid),
        .samples   (samples),
        .out_valid (out_valid),
        .median    (out_pixel)
    );

endmodule

`default_nettype wire

// File: tb/tb_median_filter_stream.sv
// ============================================================================
//  Module      : tb_median_filter_stream
//  Description : Directed self-checking bench for median_filter_stream on an
//                8x6 frame, with a 3x3 and a 5x5 instance fed in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_median_filter_stream;

    localparam int ROWS = 8;
    localparam int COLS = 6;
    localparam int NPIX = ROWS * COLS;
    localparam int OBUF = NPIX + 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       border_mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = '0;

    logic       in_ready3, out_valid3, busy3, done3;
    logic [7:0] out_pixel3;
    logic       in_ready5, out_valid5, busy5, done5;
    logic [7:0] out_pixel5;

    always #5 clk = ~clk;

    median_filter_stream #(.ROWS(ROWS), .COLS(COLS), .WINDOW(3), .PIXEL_WIDTH(8)) dut3 (
        .clk(clk), .reset(reset), .start(start), .border_mode(border_mode),
        .in_valid(in_valid), .in_ready(in_ready3), .in_pixel(in_pixel),
        .out_valid(out_valid3), .out_pixel(out_pixel3), .busy(busy3), .done(done3)
    );

    median_filter_stream #(.ROWS(ROWS), .COLS(COLS), .WINDOW(5), .PIXEL_WIDTH(8)) dut5 (
        .clk(clk), .reset(reset), .start(start), .border_mode(border_mode),
        .in_valid(in_valid), .in_ready(in_ready5), .in_pixel(in_pixel),
        .out_valid(out_valid5), .out_pixel(out_pixel5), .busy(busy5), .done(done5)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    logic [7:0] frame   [NPIX];
    logic [7:0] ref_out [NPIX];

    // ---------------- output / transfer monitor ----------------
    logic [7:0] out3  [OBUF];
    int         ocyc3 [OBUF];
    logic [7:0] out5  [OBUF];
    int         xcyc  [NPIX];
    int cnt3, done_cnt3, done_at3, done_cyc3, busy_fall3, bad_valid3;
    int cnt5, done_cnt5, bad_valid5;
    int xcnt;

    always @(negedge clk) begin
        if (out_valid3) begin
            if (cnt3 < OBUF) begin
                out3[cnt3]  = out_pixel3;
                ocyc3[cnt3] = cyc;
            end
            cnt3++;
            if (!busy3) bad_valid3++;
        end
        if (done3) begin
            done_cnt3++;
            done_at3  = cnt3;
            done_cyc3 = cyc;
        end
        if (done_cnt3 > 0 && !busy3 && busy_fall3 < 0) busy_fall3 = cyc;
        if (out_valid5) begin
            if (cnt5 < OBUF) out5[cnt5] = out_pixel5;
            cnt5++;
            if (!busy5) bad_valid5++;
        end
        if (done5) done_cnt5++;
        if (in_valid && in_ready3 && xcnt < NPIX) begin
            xcyc[xcnt] = cyc;
            xcnt++;
        end
    end

    task automatic clear_mon();
        cnt3 = 0; done_cnt3 = 0; done_at3 = -1; done_cyc3 = -100;
        busy_fall3 = -1; bad_valid3 = 0;
        cnt5 = 0; done_cnt5 = 0; bad_valid5 = 0;
        xcnt = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1. Pulses start, streams the frame; restart_at
    // re-pulses start while that pixel is offered; abort_at > 0 returns
    // right after that many transfers.
    task automatic drive_frame(input bit mode, input bit stall,
                               input int restart_at, input int abort_at);
        int  idx;
        int  guard;
        bit  took;
        start = 1'b1;
        border_mode = mode;
        @(posedge clk); #1;
        start = 1'b0;
        border_mode = ~mode;
        idx = 0;
        guard = 0;
        while (idx < NPIX && guard < 1000) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pixel = in_valid ? frame[idx] : 8'($urandom);
            start    = (idx == restart_at);
            @(negedge clk);
            took = in_valid && in_ready3;
            @(posedge clk); #1;
            if (took) idx++;
            guard++;
            if (abort_at > 0 && idx == abort_at) break;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (guard >= 1000) begin
            errors++;
            $display("FAIL drive_timeout: transferred %0d pixels, required %0d", idx, NPIX);
        end
    endtask

    // Keeps in_valid high with junk while the frame drains; none of it may
    // be accepted.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_pixel = 8'hFF;
        while ((busy3 || busy5) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy3=%0b busy5=%0b after %0d cycles, required idle", tag, busy3, busy5, n);
        end
    endtask

    task automatic check_frame_ctrl(input string tag);
        checks++;
        if (cnt3 !== NPIX) begin
            errors++; $display("FAIL %s_count: got %0d outputs, expected %0d", tag, cnt3, NPIX);
        end
        checks++;
        if (done_cnt3 !== 1) begin
            errors++; $display("FAIL %s_done_pulses: got %0d, expected 1", tag, done_cnt3);
        end
        checks++;
        if (done_at3 !== NPIX) begin
            errors++; $display("FAIL %s_done_with_output: done at output %0d, expected %0d", tag, done_at3, NPIX);
        end
        checks++;
        if (busy_fall3 !== done_cyc3 + 1) begin
            errors++; $display("FAIL %s_busy_fall: busy low at cycle %0d, expected %0d", tag, busy_fall3, done_cyc3 + 1);
        end
        checks++;
        if (bad_valid3 !== 0) begin
            errors++; $display("FAIL %s_valid_outside_busy: got %0d, expected 0", tag, bad_valid3);
        end
    endtask

    task automatic set_const(input logic [7:0] v);
        for (int k = 0; k < NPIX; k++) frame[k] = v;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < NPIX; k++) frame[k] = 8'((k / COLS) * 6 + (k % COLS));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready3, out_valid3, busy3, done3} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: in_ready/out_valid/busy/done=%b, expected 0000", {in_ready3, out_valid3, busy3, done3});
        end
        checks++;
        if (out_pixel3 !== 8'h00) begin
            errors++; $display("FAIL reset_pixel: got %h, expected 00", out_pixel3);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_const_zero_pad();
        logic [7:0] exp;
        int r, c;
        set_const(8'h80);
        clear_mon();
        drive_frame(1'b0, 1'b0, -1, 0);
        wait_idle("const0");
        check_frame_ctrl("const0");
        for (int k = 0; k < NPIX; k++) begin
            r = k / COLS;
            c = k % COLS;
            // Corners see 4 in-frame samples of 9, so the median is a pad zero.
            exp = ((r == 0 || r == ROWS - 1) && (c == 0 || c == COLS - 1)) ? 8'h00 : 8'h80;
            checks++;
            if (out3[k] !== exp) begin
                errors++; $display("FAIL const0_pix(%0d,%0d): got %h, expected %h", r, c, out3[k], exp);
            end
        end
    endtask

    task automatic test_const_replicate();
        set_const(8'h80);
        clear_mon();
        drive_frame(1'b1, 1'b0, -1, 0);
        wait_idle("const1");
        check_frame_ctrl("const1");
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (out3[k] !== 8'h80) begin
                errors++; $display("FAIL const1_pix%0d: got %h, expected 80", k, out3[k]);
            end
        end
    endtask

    task automatic test_impulse();
        set_const(8'h00);
        frame[3 * COLS + 3] = 8'hFF;
        clear_mon();
        drive_frame(1'b0, 1'b0, -1, 0);
        wait_idle("impulse");
        checks++;
        if (cnt3 !== NPIX || cnt5 !== NPIX) begin
            errors++; $display("FAIL impulse_count: got w3=%0d w5=%0d, expected %0d", cnt3, cnt5, NPIX);
        end
        checks++;
        if (done_cnt5 !== 1 || bad_valid5 !== 0) begin
            errors++; $display("FAIL impulse_w5_ctrl: done=%0d stray_valid=%0d, expected 1 and 0", done_cnt5, bad_valid5);
        end
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (out3[k] !== 8'h00 || out5[k] !== 8'h00) begin
                errors++; $display("FAIL impulse_pix%0d: got w3=%h w5=%h, expected 00", k, out3[k], out5[k]);
            end
        end
    endtask

    task automatic check_ramp_timing(input string tag);
        int exp_c;
        for (int j = 0; j < NPIX; j++) begin
            exp_c = (j <= NPIX - 8) ? xcyc[j + 7] + 2 : xcyc[NPIX - 1] + 2 + (j - (NPIX - 8));
            checks++;
            if (ocyc3[j] !== exp_c) begin
                errors++; $display("FAIL %s_timing%0d: output at cycle %0d, expected %0d", tag, j, ocyc3[j], exp_c);
            end
        end
    endtask

    task automatic test_ramp_stall();
        int pos [5];
        logic [7:0] val [5];
        // Hand-derived replicate-mode medians of pixel = 6r+c.
        pos[0] = 0;            val[0] = 8'd1;   // (0,0)
        pos[1] = 3;            val[1] = 8'd4;   // (0,3)
        pos[2] = 3 * COLS + 2; val[2] = 8'd20;  // (3,2)
        pos[3] = 4 * COLS;     val[3] = 8'd24;  // (4,0)
        pos[4] = NPIX - 1;     val[4] = 8'd46;  // (7,5)
        set_ramp();
        clear_mon();
        drive_frame(1'b1, 1'b0, -1, 0);
        wait_idle("ramp");
        check_frame_ctrl("ramp");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out3[pos[k]] !== val[k]) begin
                errors++; $display("FAIL ramp_pix%0d: got %0d, expected %0d", pos[k], out3[pos[k]], val[k]);
            end
        end
        checks++;
        if (ocyc3[2 * COLS + 2] - xcyc[3 * COLS + 3] !== 2) begin
            errors++; $display("FAIL latency_2_2: %0d cycles after input (3,3), expected 2", ocyc3[2 * COLS + 2] - xcyc[3 * COLS + 3]);
        end
        check_ramp_timing("ramp");
        for (int k = 0; k < NPIX; k++) ref_out[k] = out3[k];

        clear_mon();
        drive_frame(1'b1, 1'b1, -1, 0);
        wait_idle("stall");
        check_frame_ctrl("stall");
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (out3[k] !== ref_out[k]) begin
                errors++; $display("FAIL stall_pix%0d: got %0d, expected %0d", k, out3[k], ref_out[k]);
            end
        end
        check_ramp_timing("stall");
    endtask

    task automatic test_reset_mid_frame();
        set_ramp();
        clear_mon();
        drive_frame(1'b1, 1'b0, -1, 20);
        in_valid = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready3, out_valid3, busy3} !== 3'b000) begin
            errors++; $display("FAIL midreset_ctrl: in_ready/out_valid/busy=%b, expected 000", {in_ready3, out_valid3, busy3});
        end
        checks++;
        if (out_pixel3 !== 8'h00 || done3 !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: pixel=%h done=%b, expected 00 and 0", out_pixel3, done3);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        set_const(8'h40);
        clear_mon();
        drive_frame(1'b1, 1'b0, -1, 0);
        wait_idle("after_reset");
        check_frame_ctrl("after_reset");
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (out3[k] !== 8'h40) begin
                errors++; $display("FAIL after_reset_pix%0d: got %h, expected 40", k, out3[k]);
            end
        end
    endtask

    task automatic test_start_in_run();
        set_ramp();
        clear_mon();
        drive_frame(1'b1, 1'b0, 25, 0);
        wait_idle("restart");
        check_frame_ctrl("restart");
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (out3[k] !== ref_out[k]) begin
                errors++; $display("FAIL restart_pix%0d: got %0d, expected %0d", k, out3[k], ref_out[k]);
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_const_zero_pad();
        test_const_replicate();
        test_impulse();
        test_ramp_stall();
        test_reset_mid_frame();
        test_start_in_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
